stopwatch_ctrl: RTL and testbench
=================================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 10000000: clk cycles per count increment; legal range >= 2.
REQ-002 The block SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The block SHALL have port start_stop, input, 1: single-cycle pulse that starts or stops counting.
REQ-005 The block SHALL have port lap, input, 1: single-cycle pulse that freezes or releases the displayed value.
REQ-006 The block SHALL have port clear, input, 1: single-cycle pulse that zeroes the count.
REQ-007 The block SHALL have port hex0, output, 4: displayed ones digit, BCD.
REQ-008 The block SHALL have port hex1, output, 4: displayed tens digit, BCD.
REQ-009 The block SHALL have port hex2, output, 4: displayed hundreds digit, BCD.
REQ-010 The block SHALL have port running, output, 1: high in RUN or LAP.
REQ-011 The block SHALL have port lap_active, output, 1: high in LAP.
REQ-012 The block SHALL have port wrap, output, 1: one-cycle pulse on a 999 -> 000 rollover.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PAUSE and LAP, all registered.
REQ-014 Transitions SHALL be: IDLE+start_stop -> RUN; RUN+start_stop -> PAUSE; RUN+lap -> LAP; LAP+lap -> RUN; LAP+start_stop -> PAUSE; PAUSE+start_stop -> RUN; PAUSE+clear -> IDLE.
REQ-015 Any pulse not listed in REQ-014 for the current state SHALL be ignored; clear is ignored in RUN, LAP and IDLE.
REQ-016 Simultaneous pulses SHALL be resolved by priority clear > start_stop > lap, with only the highest applicable pulse acting.
REQ-017 The prescaler SHALL count 0..TICK_DIV-1 only in RUN or LAP and SHALL assert an internal tick in the cycle it equals TICK_DIV-1, then return to 0.
REQ-018 In PAUSE the prescaler SHALL hold its value, so a resume continues the partial interval.
REQ-019 In IDLE the prescaler SHALL be 0.
REQ-020 The first increment after IDLE -> RUN SHALL be visible exactly TICK_DIV cycles after the first cycle in RUN.
REQ-021 The count SHALL be a 3-digit BCD cascade (ones, tens, hundreds), each digit 0..9 and never 10..15; it increments by 1 on each tick.
REQ-022 At 999 the tick SHALL roll the count over to 000, assert wrap for exactly that one cycle, and keep the state unchanged.
REQ-023 On RUN -> LAP, the lap register SHALL capture the count value present in the same cycle; if a tick coincides, it captures the pre-increment value.
REQ-024 In LAP the count SHALL keep advancing and hex2..hex0 SHALL show the lap register; in all other states they SHALL show the live count.
REQ-025 On LAP -> RUN or LAP -> PAUSE, the display SHALL return to the live count in the first cycle of the new state.
REQ-026 On PAUSE -> IDLE, the count, lap register and prescaler SHALL all be 0 in the cycle after clear is sampled.
REQ-027 hex0..hex2, running and lap_active SHALL be combinational decodes of registered state only, with no input-to-output paths.

Reset
REQ-028 Asserting reset SHALL immediately, without a clock, force state IDLE, count 000, lap register 000 and prescaler 0.
REQ-029 During reset, outputs SHALL be hex0=hex1=hex2=0, running=0, lap_active=0 and wrap=0.
REQ-030 Reset asserted in any state or mid-interval SHALL discard all progress; after deassertion the block SHALL wait in IDLE for start_stop.
REQ-031 Pulses coincident with the first clock edge after reset deassertion SHALL be honoured normally.

Verification (TICK_DIV=4)
REQ-032 The bench SHALL apply reset, then start_stop and 40 cycles of wait -> running=1, display reads 010.
REQ-033 The bench SHALL start, wait 6 cycles, pulse start_stop, idle 20 cycles, pulse start_stop and wait 2 cycles -> display 001 then 002, with no count change while paused.
REQ-034 The bench SHALL preload to 998 by running 8 ticks from 990, then run 2 ticks -> display 000, wrap high for exactly 1 cycle, running still 1.
REQ-035 The bench SHALL run to 005, pulse lap and wait 12 cycles -> display holds 005, lap_active=1; it SHALL then pulse lap -> display 008 on the next cycle.
REQ-036 The bench SHALL pulse clear in RUN -> ignored; it SHALL then pulse start_stop and clear in the same cycle in PAUSE -> IDLE, display 000.
REQ-037 The bench SHALL assert reset asynchronously between clock edges in LAP -> all outputs zero before the next edge.

Source files
------------

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: a start/stop/lap/clear FSM driving a prescaled
// three-digit BCD counter, with a lap register that freezes the display.
module stopwatch_ctrl #(
    parameter int TICK_DIV = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       lap,
    input  logic       clear,
    output logic [3:0] hex0,
    output logic [3:0] hex1,
    output logic [3:0] hex2,
    output logic       running,
    output logic       lap_active,
    output logic       wrap
);

    localparam int             PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        LAP   = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       presc_q, presc_d;
    logic [2:0][3:0]     cnt_q, cnt_d;   // [0]=ones, [1]=tens, [2]=hundreds
    logic [2:0][3:0]     lap_q, lap_d;
    logic                wrap_q, wrap_d;
    logic                counting;
    logic                tick;
    logic [2:0][3:0]     disp;

    // Next-state logic; clear beats start_stop beats lap, unlisted pulses ignored.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // through the block leaves it unassigned, which would infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_stop) state_d = RUN;
            RUN:     if (start_stop) state_d = PAUSE;
                     else if (lap)   state_d = LAP;
            LAP:     if (start_stop) state_d = PAUSE;
                     else if (lap)   state_d = RUN;
            PAUSE:   if (clear)      state_d = IDLE;
                     else if (start_stop) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Prescaler, BCD cascade, lap capture and clear; all driven by registered state.
    always_comb begin
        counting = (state_q == RUN) || (state_q == LAP);
        tick     = counting && (presc_q == TICK_LAST);
        presc_d  = presc_q;
        cnt_d    = cnt_q;
        lap_d    = lap_q;
        wrap_d   = 1'b0;

        // PAUSE holds the partial interval so a resume continues it.
        if (state_q == IDLE) begin
            presc_d = '0;
        end else if (counting) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (tick) begin
            if (cnt_q[0] == 4'd9) begin
                cnt_d[0] = 4'd0;
                if (cnt_q[1] == 4'd9) begin
                    cnt_d[1] = 4'd0;
                    if (cnt_q[2] == 4'd9) begin
                        cnt_d[2] = 4'd0;
                        wrap_d   = 1'b1;
                    end else begin
                        cnt_d[2] = cnt_q[2] + 4'd1;
                    end
                end else begin
                    cnt_d[1] = cnt_q[1] + 4'd1;
                end
            end else begin
                cnt_d[0] = cnt_q[0] + 4'd1;
            end
        end

        // Capture the pre-increment count on entry to LAP.
        if ((state_q == RUN) && (state_d == LAP)) begin
            lap_d = cnt_q;
        end

        if ((state_q == PAUSE) && clear) begin
            presc_d = '0;
            cnt_d   = '0;
            lap_d   = '0;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before the edge, independent of order.
        if (reset) begin
            state_q <= IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
            lap_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            lap_q   <= lap_d;
            wrap_q  <= wrap_d;
        end
    end

    // Output decode from registered state only.
    always_comb begin
        disp       = (state_q == LAP) ? lap_q : cnt_q;
        hex0       = disp[0];
        hex1       = disp[1];
        hex2       = disp[2];
        running    = counting;
        lap_active = (state_q == LAP);
        wrap       = wrap_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random pulses, checked
// every cycle against a model that tracks total run cycles since clear.
module tb_stopwatch_ctrl;

    localparam int T = 4;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_LAP   = 3;

    logic       clk;
    logic       reset;
    logic       start_stop;
    logic       lap;
    logic       clear;
    logic [3:0] hex0, hex1, hex2;
    logic       running, lap_active, wrap;

    int n_checks = 0;
    int n_errors = 0;

    // Model: the count is simply (cycles spent running since clear) / T mod 1000.
    int m_state = S_IDLE;
    int m_run   = 0;
    int m_lap   = 0;
    int m_wrap  = 0;
    int m_live;

    stopwatch_ctrl #(.TICK_DIV(T)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .running    (running),
        .lap_active (lap_active),
        .wrap       (wrap)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model update.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_state = S_IDLE;
            m_run   = 0;
            m_lap   = 0;
            m_wrap  = 0;
        end else begin
            m_live = (m_run / T) % 1000;
            m_wrap = 0;
            if (m_state == S_RUN || m_state == S_LAP) begin
                m_run  = m_run + 1;
                m_wrap = ((m_run % (1000 * T)) == 0) ? 1 : 0;
            end
            case (m_state)
                S_IDLE:  if (start_stop) m_state = S_RUN;
                S_RUN:   if (start_stop) m_state = S_PAUSE;
                         else if (lap) begin m_lap = m_live; m_state = S_LAP; end
                S_LAP:   if (start_stop) m_state = S_PAUSE;
                         else if (lap) m_state = S_RUN;
                S_PAUSE: if (clear) begin m_state = S_IDLE; m_run = 0; m_lap = 0; end
                         else if (start_stop) m_state = S_RUN;
                default: m_state = S_IDLE;
            endcase
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_disp();
        return (m_state == S_LAP) ? m_lap : (m_run / T) % 1000;
    endfunction

    function automatic int dut_disp();
        return int'(hex2) * 100 + int'(hex1) * 10 + int'(hex0);
    endfunction

    task automatic compare_all();
        int d;
        d = exp_disp();
        check("hex0", int'(hex0), d % 10);
        check("hex1", int'(hex1), (d / 10) % 10);
        check("hex2", int'(hex2), d / 100);
        check("running", int'(running), (m_state == S_RUN || m_state == S_LAP) ? 1 : 0);
        check("lap_active", int'(lap_active), (m_state == S_LAP) ? 1 : 0);
        check("wrap", int'(wrap), m_wrap);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic pulse(input logic ss, input logic lp, input logic cl);
        @(negedge clk);
        start_stop = ss;
        lap        = lp;
        clear      = cl;
        step();
        @(negedge clk);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        compare_all();
        wait_cycles(2);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        #1;
        compare_all();
        check("reset_disp", dut_disp(), 0);
        wait_cycles(2);

        // Start and run 40 cycles: ten ticks.
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(40);
        check("run40_disp", dut_disp(), 10);
        check("run40_running", int'(running), 1);

        // Pause mid-interval, resume continues the partial interval.
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(6);
        pulse(1'b1, 1'b0, 1'b0);
        check("pause_disp", dut_disp(), 1);
        wait_cycles(20);
        check("paused_hold", dut_disp(), 1);
        check("paused_running", int'(running), 0);
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(2);
        check("resume_disp", dut_disp(), 2);

        // Run to 990, then 998, then roll over.
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(990 * T);
        check("at_990", dut_disp(), 990);
        wait_cycles(8 * T);
        check("at_998", dut_disp(), 998);
        wait_cycles(2 * T - 1);
        check("at_999", dut_disp(), 999);
        check("wrap_before", int'(wrap), 0);
        step();
        check("rollover_disp", dut_disp(), 0);
        check("wrap_pulse", int'(wrap), 1);
        check("wrap_running", int'(running), 1);
        step();
        check("wrap_after", int'(wrap), 0);

        // Lap freezes the display while the count advances.
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(5 * T);
        check("pre_lap", dut_disp(), 5);
        pulse(1'b0, 1'b1, 1'b0);
        wait_cycles(12);
        check("lap_hold", dut_disp(), 5);
        check("lap_active", int'(lap_active), 1);
        pulse(1'b0, 1'b1, 1'b0);
        check("lap_release", dut_disp(), 8);
        check("lap_released", int'(lap_active), 0);

        // Clear ignored in RUN; start_stop+clear together in PAUSE goes IDLE.
        pulse(1'b0, 1'b0, 1'b1);
        check("clear_in_run", int'(running), 1);
        pulse(1'b1, 1'b0, 1'b0);
        check("paused", int'(running), 0);
        pulse(1'b1, 1'b0, 1'b1);
        check("cleared_disp", dut_disp(), 0);
        check("cleared_running", int'(running), 0);
        wait_cycles(T * 2);
        check("idle_stays", dut_disp(), 0);

        // Asynchronous reset mid-cycle in LAP, then a start coincident with
        // the first edge after release.
        pulse(1'b1, 1'b0, 1'b0);
        wait_cycles(3 * T + 1);
        pulse(1'b0, 1'b1, 1'b0);
        wait_cycles(T);
        check("in_lap", int'(lap_active), 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        compare_all();
        check("async_disp", dut_disp(), 0);
        check("async_running", int'(running), 0);
        check("async_lap", int'(lap_active), 0);
        wait_cycles(2);
        @(negedge clk);
        reset      = 1'b0;
        start_stop = 1'b1;
        step();
        check("first_edge_start", int'(running), 1);
        @(negedge clk);
        start_stop = 1'b0;

        // Random pulses and occasional resets.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start_stop = ($urandom_range(0, 99) < 6);
            lap        = ($urandom_range(0, 99) < 6);
            clear      = ($urandom_range(0, 99) < 8);
            reset      = ($urandom_range(0, 999) < 3);
            step();
        end
        @(negedge clk);
        start_stop = 1'b0;
        lap        = 1'b0;
        clear      = 1'b0;
        reset      = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
